// File: rtl/zoom_if.sv
// Front-panel and scaling-engine signals of the zoom controller.
// The controller connects through the slave modport; the panel/engine side uses master.
interface zoom_if;
    logic [3:0] sw;
    logic       key_zoom_in_n;
    logic       key_zoom_out_n;
    logic       engine_done;
    logic [1:0] algorithm_select;
    logic [2:0] scale_exp;
    logic       engine_start;
    logic       engine_busy;
    logic       no_switch_selected_error;
    logic       multiple_switches_error;
    logic       invalid_zoom_error;

    modport master (
        output sw, key_zoom_in_n, key_zoom_out_n, engine_done,
        input  algorithm_select, scale_exp, engine_start, engine_busy,
        input  no_switch_selected_error, multiple_switches_error, invalid_zoom_error
    );

    modport slave (
        input  sw, key_zoom_in_n, key_zoom_out_n, engine_done,
        output algorithm_select, scale_exp, engine_start, engine_busy,
        output no_switch_selected_error, multiple_switches_error, invalid_zoom_error
    );
endinterface

// File: rtl/zoom_controller.sv
// Front-panel zoom controller: synchronises and debounces switches/keys, validates
// zoom requests against the algorithm class, and sequences the scaling engine.
module zoom_controller #(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int ERROR_HOLD_CYCLES = 100_000_000,
    parameter int MAX_EXP           = 2
) (
    input  logic   clk,
    input  logic   reset,
    zoom_if.slave  bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(ERROR_HOLD_CYCLES + 1);
    // Raw bit order {zoom_out_n, zoom_in_n, sw[3:0]}; keys idle released (high).
    localparam logic [5:0] RAW_IDLE = 6'b11_0000;
    localparam logic signed [3:0] MAX_S = 4'(MAX_EXP);

    typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, BUSY = 2'b10} state_t;

    function automatic logic [2:0] count_ones(input logic [3:0] v);
        count_ones = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    logic [5:0]    raw_s, sync1_r, sync2_r, deb_r, deb_prev_r;
    logic [DW-1:0] cnt_r [6];
    logic [3:0]    sw_deb_s;
    logic [2:0]    ones_s;
    logic          sw_valid_s, press_in_s, press_out_s;
    logic [1:0]    idx_s, alg_r;
    logic [2:0]    scale_r;
    logic signed [3:0] scale_ext_s, cand_s;
    logic          legal_s, alg_load_s, zoom_ok_s, zoom_bad_s, set_pend_s;
    logic          nse_r, mse_r, ize_r, pend_r, start_r, busy_r;
    logic [HW-1:0] hold_r;
    state_t        state_r, next_state_s;

    assign raw_s = {bus.key_zoom_out_n, bus.key_zoom_in_n, bus.sw};

    // Two-flop synchroniser for every raw panel input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= RAW_IDLE;
            sync2_r <= RAW_IDLE;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debouncer: accept a new level after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_r      <= RAW_IDLE;
            deb_prev_r <= RAW_IDLE;
            for (int i = 0; i < 6; i++) cnt_r[i] <= {DW{1'b0}};
        end else begin
            deb_prev_r <= deb_r;
            for (int i = 0; i < 6; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    cnt_r[i] <= {DW{1'b0}};
                end else if (cnt_r[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_r[i] <= sync2_r[i];
                    cnt_r[i] <= {DW{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + DW'(1);
                end
            end
        end
    end

    assign sw_deb_s    = deb_r[3:0];
    assign ones_s      = count_ones(sw_deb_s);
    assign sw_valid_s  = (ones_s == 3'd1);
    assign press_in_s  = deb_prev_r[4] & ~deb_r[4];
    assign press_out_s = deb_prev_r[5] & ~deb_r[5];
    assign scale_ext_s = {scale_r[2], scale_r};
    assign cand_s      = press_in_s ? (scale_ext_s + 4'sd1) : (scale_ext_s - 4'sd1);
    // Classes 00/01 only scale up, 10/11 only scale down.
    assign legal_s     = alg_r[1] ? ((cand_s >= -MAX_S) && (cand_s <= 4'sd0))
                                  : ((cand_s >= 4'sd0)  && (cand_s <= MAX_S));
    assign set_pend_s  = alg_load_s | zoom_ok_s;

    // Switch index decode and request classification.
    always_comb begin
        alg_load_s = 1'b0;
        zoom_ok_s  = 1'b0;
        zoom_bad_s = 1'b0;
        case (sw_deb_s)
            4'b0001: idx_s = 2'd0;
            4'b0010: idx_s = 2'd1;
            4'b0100: idx_s = 2'd2;
            4'b1000: idx_s = 2'd3;
            default: idx_s = 2'd0;
        endcase
        if (sw_valid_s) begin
            if (idx_s != alg_r) begin
                alg_load_s = 1'b1;
            end else if (press_in_s ^ press_out_s) begin
                if (legal_s) begin
                    zoom_ok_s = 1'b1;
                end else begin
                    zoom_bad_s = 1'b1;
                end
            end else begin
                alg_load_s = 1'b0;
            end
        end else begin
            alg_load_s = 1'b0;
        end
    end

    // Active configuration, switch flags and the timed invalid-zoom flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alg_r   <= 2'b00;
            scale_r <= 3'b000;
            nse_r   <= 1'b0;
            mse_r   <= 1'b0;
            ize_r   <= 1'b0;
            hold_r  <= {HW{1'b0}};
        end else begin
            nse_r <= (sw_deb_s == 4'b0000);
            mse_r <= (ones_s > 3'd1);
            if (alg_load_s) begin
                alg_r   <= idx_s;
                scale_r <= 3'b000;
            end else if (zoom_ok_s) begin
                scale_r <= cand_s[2:0];
            end
            if (zoom_bad_s) begin
                ize_r  <= 1'b1;
                hold_r <= HW'(ERROR_HOLD_CYCLES);
            end else if (zoom_ok_s) begin
                ize_r <= 1'b0;
            end else if (ize_r) begin
                if (hold_r == HW'(1)) ize_r <= 1'b0;
                hold_r <= hold_r - HW'(1);
            end
        end
    end

    // Engine sequencer state, registered handshake outputs and the one-deep pending request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            start_r <= (next_state_s == START);
            busy_r  <= (next_state_s != IDLE);
            pend_r  <= set_pend_s | (pend_r & (state_r != START));
        end
    end

    // Sequencer next state; a switch error holds a pending restart in IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pend_r && sw_valid_s) next_state_s = START;
                else                      next_state_s = IDLE;
            end
            START: next_state_s = BUSY;
            BUSY: begin
                if (bus.engine_done) next_state_s = IDLE;
                else                 next_state_s = BUSY;
            end
            default: next_state_s = IDLE;
        endcase
    end

    assign bus.algorithm_select         = alg_r;
    assign bus.scale_exp                = scale_r;
    assign bus.engine_start             = start_r;
    assign bus.engine_busy              = busy_r;
    assign bus.no_switch_selected_error = nse_r;
    assign bus.multiple_switches_error  = mse_r;
    assign bus.invalid_zoom_error       = ize_r;
endmodule

// File: tb/tb_zoom_controller.sv
// Self-checking bench for zoom_controller: cycle-by-cycle reference model, a table of
// panel actions with expected results, hand-written corner sequences and random stimulus.
module tb_zoom_controller;
    localparam int D  = 4;
    localparam int H  = 8;
    localparam int MX = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    zoom_if bus();
    zoom_controller #(.DEBOUNCE_CYCLES(D), .ERROR_HOLD_CYCLES(H), .MAX_EXP(MX))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0, bad = 0, cyc = 0;
    int done_cnt = 0, done_lat = 3, starts = 0;
    int last_done_cyc = -1000, last_start_cyc = -1000;
    bit rand_done = 1'b0;

    // Reference model state (bit order {out_n, in_n, sw[3:0]})
    logic [5:0] m_hist [0:D];
    logic [5:0] m_deb, m_deb_last;
    logic [1:0] m_alg;
    int  m_scl, m_expire;
    bit  m_nse, m_mse, m_ize, m_pend, m_start, m_busy;

    typedef struct {
        logic [3:0] sw;
        int         op;      // 0 none, 1 zoom-in, 2 zoom-out, 3 both keys
        logic [1:0] alg;
        logic [2:0] scl;
        logic       nse;
        logic       mse;
        int         nstart;
    } vec_t;
    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [9:0] dut_vec();
        return {bus.algorithm_select, bus.scale_exp, bus.engine_start, bus.engine_busy,
                bus.no_switch_selected_error, bus.multiple_switches_error, bus.invalid_zoom_error};
    endfunction

    function automatic logic [9:0] model_vec();
        return {m_alg, 3'(m_scl), m_start, m_busy, m_nse, m_mse, m_ize};
    endfunction

    task automatic model_reset();
        for (int k = 0; k <= D; k++) m_hist[k] = 6'b110000;
        m_deb = 6'b110000; m_deb_last = 6'b110000;
        m_alg = 2'b00; m_scl = 0; m_expire = 0;
        m_nse = 0; m_mse = 0; m_ize = 0; m_pend = 0; m_start = 0; m_busy = 0;
    endtask

    // One clock edge of the panel rules: raw reaches the debouncer two edges late,
    // and a bit flips once the D most recent such samples all disagree with it.
    task automatic model_step(input logic [5:0] raw, input bit done);
        logic [5:0] nd;
        bit all_diff, pin, pout, onehot, setp;
        int ones, idx, cand, lo, hi;
        nd = m_deb;
        for (int b = 0; b < 6; b++) begin
            all_diff = 1;
            for (int k = 1; k <= D; k++) if (m_hist[k][b] == m_deb[b]) all_diff = 0;
            if (all_diff) nd[b] = ~m_deb[b];
        end
        for (int k = D; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = raw;
        pin  = m_deb_last[4] && !m_deb[4];
        pout = m_deb_last[5] && !m_deb[5];
        ones = $countones(m_deb[3:0]);
        onehot = (ones == 1);
        idx = 0;
        for (int b = 0; b < 4; b++) if (m_deb[b]) idx = b;
        setp = 0;
        if (m_ize && cyc == m_expire) m_ize = 0;
        m_nse = (ones == 0);
        m_mse = (ones > 1);
        if (onehot) begin
            if (idx != int'(m_alg)) begin
                m_alg = 2'(idx); m_scl = 0; setp = 1;
            end else if (pin != pout) begin
                cand = m_scl + (pin ? 1 : -1);
                lo = m_alg[1] ? -MX : 0;
                hi = m_alg[1] ? 0 : MX;
                if (cand >= lo && cand <= hi) begin
                    m_scl = cand; setp = 1; m_ize = 0;
                end else begin
                    m_ize = 1; m_expire = cyc + H;
                end
            end
        end
        if (m_start) begin
            m_start = 0; m_busy = 1; m_pend = setp;
        end else if (m_busy) begin
            if (done) m_busy = 0;
            m_pend = m_pend | setp;
        end else begin
            if (m_pend && onehot) begin m_start = 1; m_busy = 1; end
            m_pend = m_pend | setp;
        end
        m_deb_last = m_deb;
        m_deb = nd;
    endtask

    task automatic step();
        logic [5:0] raw;
        bus.engine_done = (done_cnt == 1) || (rand_done && $urandom_range(0, 15) == 0);
        if (done_cnt > 0) done_cnt--;
        if (bus.engine_done) last_done_cyc = cyc;
        raw = {bus.key_zoom_out_n, bus.key_zoom_in_n, bus.sw};
        @(posedge clk);
        cyc++;
        if (reset) model_reset();
        else       model_step(raw, bus.engine_done);
        #1;
        check("cycle_outputs", 32'(dut_vec()), 32'(model_vec()));
        if (bus.engine_start) begin
            starts++; last_start_cyc = cyc; done_cnt = done_lat;
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input int which);
        if (which & 1) bus.key_zoom_in_n  = 1'b0;
        if (which & 2) bus.key_zoom_out_n = 1'b0;
        hold(D + 4);
        bus.key_zoom_in_n = 1'b1; bus.key_zoom_out_n = 1'b1;
        hold(D + 4);
    endtask

    initial begin : main
        int s0, rise_c, fall_c;
        bit seen;
        tbl[0]  = '{4'b0100, 0, 2'b10, 3'b000, 1'b0, 1'b0, 1};
        tbl[1]  = '{4'b0001, 0, 2'b00, 3'b000, 1'b0, 1'b0, 1};
        tbl[2]  = '{4'b0001, 1, 2'b00, 3'b001, 1'b0, 1'b0, 1};
        tbl[3]  = '{4'b0001, 1, 2'b00, 3'b010, 1'b0, 1'b0, 1};
        tbl[4]  = '{4'b0001, 1, 2'b00, 3'b010, 1'b0, 1'b0, 0};
        tbl[5]  = '{4'b1000, 0, 2'b11, 3'b000, 1'b0, 1'b0, 1};
        tbl[6]  = '{4'b1000, 1, 2'b11, 3'b000, 1'b0, 1'b0, 0};
        tbl[7]  = '{4'b1000, 2, 2'b11, 3'b111, 1'b0, 1'b0, 1};
        tbl[8]  = '{4'b1000, 2, 2'b11, 3'b110, 1'b0, 1'b0, 1};
        tbl[9]  = '{4'b1000, 2, 2'b11, 3'b110, 1'b0, 1'b0, 0};
        tbl[10] = '{4'b0011, 0, 2'b11, 3'b110, 1'b0, 1'b1, 0};
        tbl[11] = '{4'b0011, 1, 2'b11, 3'b110, 1'b0, 1'b1, 0};
        tbl[12] = '{4'b0010, 0, 2'b01, 3'b000, 1'b0, 1'b0, 1};
        tbl[13] = '{4'b0010, 3, 2'b01, 3'b000, 1'b0, 1'b0, 0};
        tbl[14] = '{4'b0000, 0, 2'b01, 3'b000, 1'b1, 1'b0, 0};
        tbl[15] = '{4'b0000, 1, 2'b01, 3'b000, 1'b1, 1'b0, 0};
        tbl[16] = '{4'b0010, 0, 2'b01, 3'b000, 1'b0, 1'b0, 0};

        bus.sw = 4'b0000; bus.key_zoom_in_n = 1'b1; bus.key_zoom_out_n = 1'b1;
        bus.engine_done = 1'b0;
        reset = 1'b1;
        model_reset();
        hold(2);
        check("reset_values", 32'(dut_vec()), 32'd0);
        reset = 1'b0;
        step();
        check("nse_first_edge", 32'(bus.no_switch_selected_error), 32'd1);

        for (int i = 0; i < 17; i++) begin
            s0 = starts;
            bus.sw = tbl[i].sw;
            if (tbl[i].op == 0) hold(D + 4);
            else                press(tbl[i].op);
            hold(24);
            check($sformatf("vec%0d_alg", i), 32'(bus.algorithm_select), 32'(tbl[i].alg));
            check($sformatf("vec%0d_scale", i), 32'(bus.scale_exp), 32'(tbl[i].scl));
            check($sformatf("vec%0d_flags", i),
                  32'({bus.no_switch_selected_error, bus.multiple_switches_error}),
                  32'({tbl[i].nse, tbl[i].mse}));
            check($sformatf("vec%0d_starts", i), 32'(starts - s0), 32'(tbl[i].nstart));
        end

        // Illegal zoom-out on an upscale algorithm: flag width must be exactly H cycles
        bus.key_zoom_out_n = 1'b0;
        seen = 0; rise_c = 0; fall_c = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            if (bus.invalid_zoom_error) begin seen = 1; rise_c = cyc; end
        end
        check("ize_rise_seen", 32'(seen), 32'd1);
        bus.key_zoom_out_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            if (!bus.invalid_zoom_error) begin seen = 1; fall_c = cyc; end
        end
        check("ize_fall_seen", 32'(seen), 32'd1);
        check("ize_hold_cycles", 32'(fall_c - rise_c), 32'(H));
        check("ize_scale_kept", 32'(bus.scale_exp), 32'd0);
        hold(D + 4);

        // Two zoom-ins during a long engine run coalesce into one restart
        done_lat = 100;
        s0 = starts;
        bus.sw = 4'b0001;
        hold(D + 6);
        check("long_run_started", 32'(starts - s0), 32'd1);
        check("long_run_busy", 32'(bus.engine_busy), 32'd1);
        press(1);
        press(1);
        done_lat = 3;
        check("coalesce_scale", 32'(bus.scale_exp), 32'd2);
        check("coalesce_no_early_start", 32'(starts - s0), 32'd1);
        for (int k = 0; k < 120 && (starts - s0) < 2; k++) step();
        check("restart_count", 32'(starts - s0), 32'd2);
        check("restart_spacing", 32'(last_start_cyc - last_done_cyc), 32'd2);
        hold(20);
        check("single_restart", 32'(starts - s0), 32'd2);

        // Sub-threshold glitch on zoom-out must not produce an event
        s0 = starts;
        bus.key_zoom_out_n = 1'b0;
        hold(D - 1);
        bus.key_zoom_out_n = 1'b1;
        hold(20);
        check("glitch_scale", 32'(bus.scale_exp), 32'd2);
        check("glitch_starts", 32'(starts - s0), 32'd0);

        // Reset while the engine is busy abandons the run for good
        done_lat = 100;
        bus.key_zoom_out_n = 1'b0;
        hold(D + 6);
        check("pre_reset_busy", 32'(bus.engine_busy), 32'd1);
        check("pre_reset_scale", 32'(bus.scale_exp), 32'd1);
        bus.key_zoom_out_n = 1'b1;
        reset = 1'b1;
        #1;
        model_reset();
        done_cnt = 0;
        check("async_reset_clear", 32'(dut_vec()), 32'd0);
        hold(2);
        reset = 1'b0;
        done_lat = 3;
        s0 = starts;
        hold(30);
        check("no_start_after_reset", 32'(starts - s0), 32'd0);
        check("alg_after_reset", 32'(bus.algorithm_select), 32'd0);
        check("scale_after_reset", 32'(bus.scale_exp), 32'd0);

        // Random panel activity against the model, including stray done pulses
        rand_done = 1'b1;
        for (int it = 0; it < 160; it++) begin
            int r, len;
            r = $urandom_range(0, 9);
            len = $urandom_range(1, 8);
            case (r)
                0, 1, 2, 3: bus.sw = 4'(1 << $urandom_range(0, 3));
                4:          bus.sw = 4'($urandom_range(0, 15));
                5: begin bus.key_zoom_in_n = 1'b0; hold(len); bus.key_zoom_in_n = 1'b1; end
                6: begin bus.key_zoom_out_n = 1'b0; hold(len); bus.key_zoom_out_n = 1'b1; end
                7: begin
                    bus.key_zoom_in_n = 1'b0; bus.key_zoom_out_n = 1'b0;
                    hold(len);
                    bus.key_zoom_in_n = 1'b1; bus.key_zoom_out_n = 1'b1;
                end
                8:       done_lat = $urandom_range(1, 12);
                default: hold(1);
            endcase
            hold($urandom_range(1, 14));
        end
        rand_done = 1'b0;
        hold(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/zoom_controller.md
# zoom_controller

Front-panel controller for the image scaling datapath. Debounces the four algorithm switches and the two zoom pushbuttons, validates the requested operation, and holds the active algorithm and scale exponent. Sequences the scaling engine with a start/done handshake and drives the algorithm code and three error flags consumed by the scrolling HEX text display.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before an input change is accepted (20 ms at 50 MHz)
- ERROR_HOLD_CYCLES, 100_000_000, cycles invalid_zoom_error stays asserted (2 s)
- MAX_EXP, 2, magnitude limit of scale_exp (factors 1/4 .. 4x)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- sw  in  4  raw algorithm switches, one-hot: [0] nearest neighbor, [1] pixel replication, [2] decimation, [3] block averaging
- key_zoom_in_n  in  1  raw pushbutton, active-low
- key_zoom_out_n  in  1  raw pushbutton, active-low
- engine_done  in  1  one-cycle pulse from scaling engine, operation complete
- algorithm_select  out  2  active algorithm (index of the set switch)
- scale_exp  out  3  signed two's complement; factor = 2^scale_exp
- engine_start  out  1  one-cycle start pulse
- engine_busy  out  1  high from engine_start until engine_done
- no_switch_selected_error  out  1  debounced sw == 0
- multiple_switches_error  out  1  more than one debounced sw bit set
- invalid_zoom_error  out  1  last zoom request rejected

## Operation
- Input path: every raw input gets a 2-flop synchronizer, then a per-bit debouncer; debounced value updates after DEBOUNCE_CYCLES consecutive cycles of a stable, differing synchronized value. Debounced sw resets to 0; debounced keys reset to released.
- Key event: debounced falling edge (press), one cycle wide. Zoom-in and zoom-out events in the same cycle: both discarded, no error.
- Switch flags: registered from debounced sw each cycle. Exactly one bit set: both flags 0; if the index differs from algorithm_select, load it, force scale_exp to 0, set cfg_pending.
- Algorithm class: 00/01 are upscale (legal scale_exp 0..+MAX_EXP); 10/11 are downscale (legal -MAX_EXP..0).
- Zoom event with valid switches: candidate = scale_exp +1 (in) or -1 (out). Legal: update scale_exp, set cfg_pending. Illegal (wrong direction or beyond MAX_EXP): scale_exp unchanged, invalid_zoom_error = 1, hold counter loaded with ERROR_HOLD_CYCLES; a new illegal request reloads the counter; a legal request clears the flag at once.
- Zoom event while a switch error is active: ignored, no flag change.
- FSM IDLE: cfg_pending and no switch error -> START. START: engine_start = 1, clear cfg_pending -> BUSY. BUSY: engine_busy = 1; engine_done -> IDLE. engine_done outside BUSY is ignored.
- Requests during START/BUSY update scale_exp/algorithm_select immediately and set cfg_pending (one-deep; multiple requests coalesce into one restart with the latest config). The engine samples configuration only in the START cycle.
- Switch error during BUSY does not abort; the restart is held in IDLE until the switches are valid again.

## Timing
- Reset values: algorithm_select 00, scale_exp 000, engine_start 0, engine_busy 0, all three error flags 0, FSM IDLE, cfg_pending 0.
- After reset release with sw = 0, no_switch_selected_error rises on the first clock edge.
- Raw input to debounced value: 2 + DEBOUNCE_CYCLES cycles. Debounced change to flags/algorithm_select/scale_exp: +1 cycle. Config update to engine_start: 2 cycles (IDLE->START, START output).
- engine_busy rises with engine_start and falls on the cycle after engine_done is sampled. Minimum restart spacing is 2 cycles after done.
- invalid_zoom_error falls exactly ERROR_HOLD_CYCLES cycles after its last assertion.
- Reset mid-operation clears everything immediately; any in-flight engine operation is abandoned and not restarted.

## Test plan
- DEBOUNCE_CYCLES=4, ERROR_HOLD_CYCLES=8. Reset with sw=0000 -> no_switch_selected_error=1 from the first clock edge; set sw=0100 -> flag 0, algorithm_select=10, one engine_start pulse, engine_busy until engine_done.
- sw=0001, press zoom-in 3 times with done between -> scale_exp 1,2,2; third press sets invalid_zoom_error, which drops 8 cycles later.
- sw=1000, zoom-in once -> invalid_zoom_error=1, scale_exp stays 0; zoom-out twice -> -1, -2, flag cleared on the first legal press.
- sw=0011 -> multiple_switches_error=1, zoom presses ignored, no engine_start; return to 0010 -> algorithm_select=01, scale_exp=0, one start.
- Two zoom-in presses during BUSY -> scale_exp +2, exactly one engine_start 2 cycles after engine_done; a glitch shorter than 4 cycles on a key -> no event.
- Both keys pressed in the same cycle -> no change, no error; reset asserted during BUSY -> all outputs at reset values, no start after release until a new request.
